// File: rtl/pipe_scoreboard.sv
// Register scoreboard: tracks pending register writes, gates issue on RAW/WAW hazards and limits writes in flight.
// Optional macro SCOREBOARD_BYPASS_EN lets a same-cycle writeback release the hazard it clears.
module pipe_scoreboard #(
    parameter int NUM_REGS     = 32,
    parameter int IDX_W        = 5,
    parameter int MAX_INFLIGHT = 4,
    parameter int CNT_W        = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                iss_valid,
    output logic                iss_ready,
    input  logic [IDX_W-1:0]    iss_rs1,
    input  logic [IDX_W-1:0]    iss_rs2,
    input  logic                iss_rs1_use,
    input  logic                iss_rs2_use,
    input  logic [IDX_W-1:0]    iss_rd,
    input  logic                iss_rd_we,
    input  logic                wb_valid,
    input  logic [IDX_W-1:0]    wb_rd,
    input  logic                flush,
    output logic [NUM_REGS-1:0] busy_mask,
    output logic [CNT_W-1:0]    inflight,
    output logic                err,
    output logic [15:0]         stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_INFLIGHT);

    logic [NUM_REGS-1:0] pend, pend_nxt, haz_view;
    logic                wb_hit, full, hazard, fire, do_set, do_clr, bad_wb;

    assign wb_hit = wb_valid & (wb_rd != '0) & pend[wb_rd];

`ifdef SCOREBOARD_BYPASS_EN
    // A retiring write frees both its register and its inflight slot in the same cycle.
    assign haz_view = pend & ~(NUM_REGS'(wb_hit) << wb_rd);
    assign full     = (inflight == CNT_MAX) & ~wb_hit;
`else
    assign haz_view = pend;
    assign full     = (inflight == CNT_MAX);
`endif

    assign hazard = (iss_rs1_use & haz_view[iss_rs1])
                  | (iss_rs2_use & haz_view[iss_rs2])
                  | (iss_rd_we   & haz_view[iss_rd])
                  | (iss_rd_we   & (iss_rd != '0) & full);

    assign iss_ready = rst & ~flush & ~hazard;
    assign fire      = iss_valid & iss_ready;
    assign do_set    = fire & iss_rd_we & (iss_rd != '0);
    assign do_clr    = wb_hit;
    assign bad_wb    = wb_valid & ~wb_hit;

    // Set wins over clear when issue and writeback target the same register.
    assign pend_nxt[0] = 1'b0;
    for (genvar g = 1; g < NUM_REGS; g++) begin : g_pend
        assign pend_nxt[g] = (do_set & (iss_rd == IDX_W'(g)))
                           | (pend[g] & ~(do_clr & (wb_rd == IDX_W'(g))));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pend      <= '0;
            inflight  <= '0;
            err       <= 1'b0;
            stall_cnt <= '0;
        end else begin
            if (iss_valid && !iss_ready && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 16'd1;
            if (flush) begin
                pend     <= '0;
                inflight <= '0;
            end else begin
                pend <= pend_nxt;
                err  <= err | bad_wb;
                if (do_set && !do_clr && inflight != CNT_MAX)
                    inflight <= inflight + CNT_W'(1);
                else if (do_clr && !do_set && inflight != '0)
                    inflight <= inflight - CNT_W'(1);
            end
        end
    end

    assign busy_mask = pend;

endmodule

// File: tb/tb_pipe_scoreboard.sv
// Directed bench for pipe_scoreboard: vector table plus hand sequences for capacity, bypass, flush and reset.
module tb_pipe_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        iss_valid, iss_ready, iss_rs1_use, iss_rs2_use, iss_rd_we;
    logic [4:0]  iss_rs1, iss_rs2, iss_rd, wb_rd;
    logic        wb_valid, flush;
    logic [31:0] busy_mask;
    logic [2:0]  inflight;
    logic        err;
    logic [15:0] stall_cnt;

    int checks = 0;
    int failures = 0;

    pipe_scoreboard dut (
        .clk(clk), .rst(rst), .iss_valid(iss_valid), .iss_ready(iss_ready),
        .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_rs1_use(iss_rs1_use),
        .iss_rs2_use(iss_rs2_use), .iss_rd(iss_rd), .iss_rd_we(iss_rd_we),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
        .busy_mask(busy_mask), .inflight(inflight), .err(err), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        v;
        logic [4:0]  rs1;
        logic        u1;
        logic [4:0]  rs2;
        logic        u2;
        logic [4:0]  rd;
        logic        we;
        logic        wbv;
        logic [4:0]  wbrd;
        logic        fl;
        logic        e_rdy;
        logic [31:0] e_busy;
        logic [2:0]  e_infl;
        logic        e_err;
        logic [15:0] e_stall;
    } vec_t;

    vec_t tbl [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic setin(input logic v, input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                         input logic we, input logic wbv, input logic [4:0] wbrd, input logic fl);
        iss_valid = v; iss_rs1 = rs1; iss_rs1_use = u1; iss_rs2 = rs2; iss_rs2_use = u2;
        iss_rd = rd; iss_rd_we = we; wb_valid = wbv; wb_rd = wbrd; flush = fl;
        #1;
    endtask

    task automatic idle();
        setin(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_rd(input logic [4:0] rd);
        setin(1, 0, 0, 0, 0, rd, 1, 0, 0, 0);
        chk("issue_ready", {31'b0, iss_ready}, 32'd1);
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle();
        tick();
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        idle();
        tick();
        tick();
        // Ready must stay low under reset even with a hazard-free request.
        setin(1, 0, 0, 0, 0, 3, 1, 0, 0, 0);
        chk("ready_in_reset", {31'b0, iss_ready}, 32'd0);
        tick();
        chk("rst_busy", busy_mask, 32'd0);
        chk("rst_infl", {29'b0, inflight}, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        chk("rst_stall", {16'b0, stall_cnt}, 32'd0);
        rst = 1'b1;

        //             v rs1 u1 rs2 u2 rd we wbv wbrd fl rdy busy        infl err stall
        tbl[0]  = '{1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 32'h20, 3'd1, 1'b0, 16'd0};
        tbl[1]  = '{1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h20, 3'd1, 1'b0, 16'd1};
        tbl[2]  = '{1'b1, 5'd3, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h20, 3'd1, 1'b0, 16'd2};
        tbl[3]  = '{1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h20, 3'd1, 1'b0, 16'd2};
        tbl[4]  = '{1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 32'h20, 3'd1, 1'b0, 16'd2};
        tbl[5]  = '{1'b1, 5'd5, 1'b0, 5'd5, 1'b0, 5'd7, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 32'hA0, 3'd2, 1'b0, 16'd2};
        tbl[6]  = '{1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b1, 32'h80, 3'd1, 1'b0, 16'd2};
        tbl[7]  = '{1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 32'h80, 3'd1, 1'b0, 16'd3};
        tbl[8]  = '{1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd1, 1'b1, 1'b1, 5'd7, 1'b0, 1'b1, 32'h02, 3'd1, 1'b0, 16'd3};
        tbl[9]  = '{1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd9, 1'b0, 1'b1, 32'h02, 3'd1, 1'b1, 16'd3};
        tbl[10] = '{1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b1, 32'h02, 3'd1, 1'b1, 16'd3};
        tbl[11] = '{1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd1, 1'b0, 1'b1, 32'h00, 3'd0, 1'b1, 16'd3};
        tbl[12] = '{1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 32'h00, 3'd0, 1'b1, 16'd3};

        for (int i = 0; i < 13; i++) begin
            setin(tbl[i].v, tbl[i].rs1, tbl[i].u1, tbl[i].rs2, tbl[i].u2,
                  tbl[i].rd, tbl[i].we, tbl[i].wbv, tbl[i].wbrd, tbl[i].fl);
            chk($sformatf("v%0d_ready", i), {31'b0, iss_ready}, {31'b0, tbl[i].e_rdy});
            tick();
            chk($sformatf("v%0d_busy", i), busy_mask, tbl[i].e_busy);
            chk($sformatf("v%0d_infl", i), {29'b0, inflight}, {29'b0, tbl[i].e_infl});
            chk($sformatf("v%0d_err", i), {31'b0, err}, {31'b0, tbl[i].e_err});
            chk($sformatf("v%0d_stall", i), {16'b0, stall_cnt}, {16'b0, tbl[i].e_stall});
        end

        // Capacity: four writes fill the window; rd=0 is still allowed.
        for (int r = 1; r <= 4; r++) issue_rd(5'(r));
        chk("cap_infl", {29'b0, inflight}, 32'd4);
        chk("cap_busy", busy_mask, 32'h1E);
        issue_rd(5'd0);
        setin(1, 0, 0, 0, 0, 6, 1, 0, 0, 0);
        chk("cap_full_ready", {31'b0, iss_ready}, 32'd0);
        tick();
        chk("cap_full_stall", {16'b0, stall_cnt}, 32'd4);
        setin(1, 0, 0, 0, 0, 6, 1, 1, 1, 0);
`ifdef SCOREBOARD_BYPASS_EN
        chk("cap_byp_ready", {31'b0, iss_ready}, 32'd1);
        tick();
        chk("cap_byp_infl", {29'b0, inflight}, 32'd4);
        chk("cap_byp_busy", busy_mask, 32'h5C);
`else
        chk("cap_nb_ready", {31'b0, iss_ready}, 32'd0);
        tick();
        chk("cap_nb_infl", {29'b0, inflight}, 32'd3);
        chk("cap_nb_busy", busy_mask, 32'h1C);
        issue_rd(5'd6);
        chk("cap_nb_infl2", {29'b0, inflight}, 32'd4);
        chk("cap_nb_busy2", busy_mask, 32'h5C);
`endif
        chk("err_sticky", {31'b0, err}, 32'd1);

        // Bypass of a dependent read against a same-cycle writeback.
        do_reset();
        chk("err_cleared", {31'b0, err}, 32'd0);
        issue_rd(5'd5);
        setin(1, 5, 1, 0, 0, 0, 0, 1, 5, 0);
`ifdef SCOREBOARD_BYPASS_EN
        chk("raw_byp_ready", {31'b0, iss_ready}, 32'd1);
        tick();
        chk("raw_byp_stall", {16'b0, stall_cnt}, 32'd0);
`else
        chk("raw_nb_ready", {31'b0, iss_ready}, 32'd0);
        tick();
        setin(1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
        chk("raw_nb_ready_next", {31'b0, iss_ready}, 32'd1);
        tick();
        chk("raw_nb_stall", {16'b0, stall_cnt}, 32'd1);
`endif
        chk("raw_busy", busy_mask, 32'd0);
        chk("raw_infl", {29'b0, inflight}, 32'd0);

        // Flush with three pending and a valid writeback in the same cycle.
        for (int r = 2; r <= 4; r++) issue_rd(5'(r));
        chk("fl_pre_infl", {29'b0, inflight}, 32'd3);
        setin(1, 0, 0, 0, 0, 8, 1, 1, 2, 1);
        chk("fl_ready", {31'b0, iss_ready}, 32'd0);
        tick();
        chk("fl_busy", busy_mask, 32'd0);
        chk("fl_infl", {29'b0, inflight}, 32'd0);
        chk("fl_err", {31'b0, err}, 32'd0);

        // Reset mid-operation overrides issue and writeback.
        do_reset();
        for (int r = 1; r <= 3; r++) issue_rd(5'(r));
        setin(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        repeat (7) tick();
        chk("mid_infl", {29'b0, inflight}, 32'd3);
        chk("mid_stall", {16'b0, stall_cnt}, 32'd7);
        rst = 1'b0;
        setin(1, 0, 0, 0, 0, 9, 1, 1, 1, 0);
        chk("mid_rst_ready", {31'b0, iss_ready}, 32'd0);
        tick();
        chk("mid_rst_busy", busy_mask, 32'd0);
        chk("mid_rst_infl", {29'b0, inflight}, 32'd0);
        chk("mid_rst_err", {31'b0, err}, 32'd0);
        chk("mid_rst_stall", {16'b0, stall_cnt}, 32'd0);
        rst = 1'b1;
        issue_rd(5'd5);
        chk("resume_busy", busy_mask, 32'h20);
        chk("resume_infl", {29'b0, inflight}, 32'd1);
        idle();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_scoreboard.md
PIPE_SCOREBOARD -- requirements
Module: pipe_scoreboard

Interface
REQ-001 SHALL have parameter NUM_REGS, default 32, number of architectural registers; register 0 is hardwired zero.
REQ-002 SHALL have parameter IDX_W, default 5, register index width (clog2(NUM_REGS)).
REQ-003 SHALL have parameter MAX_INFLIGHT, default 4, maximum outstanding register writes.
REQ-004 SHALL have parameter CNT_W, default 3, inflight counter width (clog2(MAX_INFLIGHT+1)).
REQ-005 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-006 SHALL have port rst  in  1  reset, synchronous, active-low.
REQ-007 SHALL have port iss_valid  in  1  decode presents an instruction for issue.
REQ-008 SHALL have port iss_ready  out  1  scoreboard permits issue this cycle.
REQ-009 SHALL have ports iss_rs1, iss_rs2  in  IDX_W  source register indices.
REQ-010 SHALL have ports iss_rs1_use, iss_rs2_use  in  1  qualifiers for the source indices.
REQ-011 SHALL have ports iss_rd  in  IDX_W and iss_rd_we  in  1  destination index and write qualifier.
REQ-012 SHALL have ports wb_valid  in  1 and wb_rd  in  IDX_W  register-file write port retiring a pending write.
REQ-013 SHALL have port flush  in  1  squash all in-flight writes.
REQ-014 SHALL have port busy_mask  out  NUM_REGS  registered pending-write vector.
REQ-015 SHALL have port inflight  out  CNT_W  number of outstanding writes.
REQ-016 SHALL have port err  out  1  sticky protocol-violation flag.
REQ-017 SHALL have port stall_cnt  out  16  saturating count of stalled issue cycles.

Function
REQ-018 hazard SHALL be (rs1_use & pend[rs1]) | (rs2_use & pend[rs2]) | (rd_we & pend[rd]) | (rd_we & rd!=0 & inflight==MAX_INFLIGHT).
REQ-019 iss_ready SHALL be combinational: !hazard & !flush; zero added latency from registered state.
REQ-020 issue fire SHALL be iss_valid & iss_ready; fire with rd_we & rd!=0 SHALL set pend[rd] and increment inflight on the next edge.
REQ-021 pend[0] SHALL always read 0; an issue with rd==0 SHALL neither set a bit nor change inflight.
REQ-022 wb_valid with pend[wb_rd]==1 SHALL clear pend[wb_rd] and decrement inflight on the next edge.
REQ-023 wb_valid with pend[wb_rd]==0 or wb_rd==0 SHALL leave state unchanged and set err (sticky).
REQ-024 simultaneous fire-increment and valid retire SHALL leave inflight unchanged; both bit updates apply.
REQ-025 simultaneous set and clear of the same index SHALL leave the bit set (set wins).
REQ-026 flush SHALL clear busy_mask and inflight on the next edge; wb_valid in the flush cycle SHALL be ignored (no err).
REQ-027 stall_cnt SHALL increment on each cycle with iss_valid & !iss_ready, saturating at 0xFFFF.
REQ-028 inflight SHALL never exceed MAX_INFLIGHT nor wrap below 0.

Reset
REQ-029 with rst==0 at a rising edge, busy_mask, inflight, err and stall_cnt SHALL be 0 after that edge.
REQ-030 reset SHALL override issue, writeback and flush in the same cycle; iss_ready SHALL be 0 while rst==0.

Configuration
REQ-031 macro SCOREBOARD_BYPASS_EN defined: a same-cycle valid wb_valid to index r SHALL mask pend[r] in the REQ-018 hazard terms and count as a free slot for the inflight-limit term.
REQ-032 macro SCOREBOARD_BYPASS_EN undefined: hazard SHALL use registered state only; the dependent instruction issues one cycle after writeback.

Verification
REQ-033 reset, issue rd=5 rd_we=1 -> busy_mask=0x20, inflight=1; next issue rs1=5 use=1 -> iss_ready=0, stall_cnt increments.
REQ-034 pend[5] set, wb_valid wb_rd=5 with dependent rs1=5 waiting -> bypass build: iss_ready=1 same cycle; non-bypass: iss_ready=1 next cycle.
REQ-035 issue to rd=1,2,3,4 -> inflight=4; issue rd=6 -> iss_ready=0; same cycle wb_rd=1 -> inflight stays 4 after a bypassed issue.
REQ-036 issue rd=0 rd_we=1 -> busy_mask=0, inflight=0; wb_valid wb_rd=9 with nothing pending -> err=1, stays 1 until reset.
REQ-037 three pending writes, flush=1 with wb_valid wb_rd pending -> busy_mask=0, inflight=0, err=0; iss_ready=0 during flush cycle.
REQ-038 rst=0 asserted mid-operation with inflight=3 and stall_cnt=7 -> all outputs 0 after the edge; state resumes cleanly after rst=1.
